// File: rtl/lal_frame_tx.sv
// lal_frame_tx: transmit end of the lal address/count link.
//
// A send request (start, accepted only when idle and not inhibited) carries
// a destination address and a data-beat count.  The block then emits one
// frame on the tx_* valid/ready channel:
//   ADDR beat (tag 01, payload = dest)
//   len DATA beats (tag 10, payload = running sequence count)
//   END beat  (tag 11, payload = len)
// Only one frame is in flight at a time, and no requests are queued.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           frame request, sampled only while idle
//   dest, len       destination address and DATA beat count, captured on acceptance
//   inhibit         blocks acceptance of start while high
//   tx_valid/ready  beat handshake, transfer when both are high
//   tx_tag          00 none, 01 ADDR, 10 DATA, 11 END
//   tx_data         beat payload (CNT_W bits)
//   busy            high whenever a frame is in progress
//   done            one-cycle pulse after the END beat transfers
//   seq             sequence counter, persists across frames
//   tx_par          (only with LAL_FRAME_TX_PARITY_EN) even parity over
//                   {tx_par, tx_tag, tx_data}
//
// Optional feature macro: LAL_FRAME_TX_PARITY_EN
// All outputs are registered.

module lal_frame_tx #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 9,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest,
  input  logic [LEN_W-1:0]  len,
  input  logic              inhibit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [1:0]        tx_tag,
  output logic [CNT_W-1:0]  tx_data,
  output logic              busy,
  output logic              done,
`ifdef LAL_FRAME_TX_PARITY_EN
  output logic              tx_par,
`endif
  output logic [CNT_W-1:0]  seq
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_END} state_t;

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_ADDR = 2'b01;
  localparam logic [1:0] TAG_DATA = 2'b10;
  localparam logic [1:0] TAG_END  = 2'b11;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               tx_valid_q, tx_valid_d;
  logic [1:0]         tx_tag_q, tx_tag_d;
  logic [CNT_W-1:0]   tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   seq_q, seq_d;
  logic               xfer;

  assign xfer = tx_valid_q & tx_ready;

  // Next-beat values are computed here and registered, so the outputs never
  // depend combinationally on any input.  Defaults hold every register, which
  // keeps tag and payload stable while the link applies backpressure.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rem_d      = rem_q;
    tx_valid_d = tx_valid_q;
    tx_tag_d   = tx_tag_q;
    tx_data_d  = tx_data_q;
    seq_d      = seq_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !inhibit) begin
          len_d      = len;
          rem_d      = len;
          state_d    = S_ADDR;
          tx_valid_d = 1'b1;
          tx_tag_d   = TAG_ADDR;
          tx_data_d  = CNT_W'(dest);
        end
      end
      S_ADDR: begin
        if (xfer) begin
          if (len_q != '0) begin
            state_d   = S_DATA;
            tx_tag_d  = TAG_DATA;
            tx_data_d = seq_q;
          end else begin
            state_d   = S_END;
            tx_tag_d  = TAG_END;
            tx_data_d = CNT_W'(len_q);
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          // Counter wraps naturally at 2^CNT_W.
          seq_d = seq_q + CNT_W'(1);
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d   = S_END;
            tx_tag_d  = TAG_END;
            tx_data_d = CNT_W'(len_q);
          end else begin
            tx_data_d = seq_d;
          end
        end
      end
      S_END: begin
        if (xfer) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
          tx_tag_d   = TAG_NONE;
          tx_data_d  = '0;
          done_d     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rem_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_tag_q   <= TAG_NONE;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      seq_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      tx_valid_q <= tx_valid_d;
      tx_tag_q   <= tx_tag_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      seq_q      <= seq_d;
    end
  end

`ifdef LAL_FRAME_TX_PARITY_EN
  logic tx_par_q, tx_par_d;

  // Parity follows the registered beat, so it is 0 when idle (tag and data
  // are both zero) and holds whenever the beat holds.
  always_comb begin
    tx_par_d = ^{tx_tag_d, tx_data_d};
  end

  always_ff @(posedge clk) begin
    if (rst) tx_par_q <= 1'b0;
    else     tx_par_q <= tx_par_d;
  end

  assign tx_par = tx_par_q;
`endif

  assign tx_valid = tx_valid_q;
  assign tx_tag   = tx_tag_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign seq      = seq_q;

endmodule

// File: tb/tb_lal_frame_tx.sv
// Self-checking bench for lal_frame_tx.  Each frame's expected beat list is
// built from the framing rules (ADDR/dest, len DATA beats of the running
// count, END/len) and compared against the transfers observed on the link.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_lal_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dest;
  logic [3:0] len;
  logic       inhibit;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] tx_tag;
  logic [8:0] tx_data;
  logic       busy;
  logic       done;
  logic [8:0] seq;
`ifdef LAL_FRAME_TX_PARITY_EN
  logic       tx_par;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] model_seq = '0;

  always #5 clk = ~clk;

  lal_frame_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dest     (dest),
    .len      (len),
    .inhibit  (inhibit),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_tag   (tx_tag),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
`ifdef LAL_FRAME_TX_PARITY_EN
    .tx_par   (tx_par),
`endif
    .seq      (seq)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dest = '0; len = '0; inhibit = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_valid, busy, done, tx_tag, tx_data, seq} !== 15'd0) begin
      errors++;
      $display("FAIL reset: valid=%0b busy=%0b done=%0b tag=%0b data=%0d seq=%0d, required all 0",
               tx_valid, busy, done, tx_tag, tx_data, seq);
    end
`ifdef LAL_FRAME_TX_PARITY_EN
    checks++;
    if (tx_par !== 1'b0) begin errors++; $display("FAIL reset_par: got %0b required 0", tx_par); end
`endif
    model_seq = '0;
    $display("reset: valid=%0b busy=%0b seq=%0d", tx_valid, busy, seq);
  endtask

  // Sends one frame starting at the current falling edge and returns at the
  // falling edge where done is expected high.  mode: 0 ready held high,
  // 1 ready toggling 1/0, 2 random ready.
  task automatic send_frame(input logic [3:0] d, input logic [3:0] l, input int mode);
    logic [1:0] exp_tag[$];
    logic [8:0] exp_data[$];
    logic [8:0] s;
    logic [1:0] ptag;
    logic [8:0] pdata;
    logic       stall;
    logic       r;
    logic       tog;
    int         cyc;
    int         beats;

    exp_tag.push_back(2'b01); exp_data.push_back({5'd0, d});
    s = model_seq;
    for (int i = 0; i < int'(l); i++) begin
      exp_tag.push_back(2'b10); exp_data.push_back(s);
      s = s + 9'd1;
    end
    exp_tag.push_back(2'b11); exp_data.push_back({5'd0, l});

    start = 1'b1; dest = d; len = l; inhibit = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_tag !== 2'b01 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL accept: valid=%0b tag=%0b busy=%0b done=%0b, required 1/01/1/0",
               tx_valid, tx_tag, busy, done);
    end

    stall = 1'b0; tog = 1'b1; cyc = 0; beats = 0; ptag = '0; pdata = '0;
    while (exp_tag.size() > 0 && cyc < 200) begin
      checks++;
      if (tx_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL in_frame: valid=%0b busy=%0b done=%0b, required 1/1/0", tx_valid, busy, done);
      end
      checks++;
      if (seq !== model_seq) begin
        errors++;
        $display("FAIL seq_live: got %0d required %0d", seq, model_seq);
      end
      if (stall) begin
        checks++;
        if (tx_tag !== ptag || tx_data !== pdata) begin
          errors++;
          $display("FAIL hold: tag=%0b data=%0d, required tag=%0b data=%0d", tx_tag, tx_data, ptag, pdata);
        end
      end
`ifdef LAL_FRAME_TX_PARITY_EN
      checks++;
      if (($countones({tx_par, tx_tag, tx_data}) % 2) != 0) begin
        errors++;
        $display("FAIL parity: par=%0b tag=%0b data=%0d, required even ones", tx_par, tx_tag, tx_data);
      end
`endif
      case (mode)
        0:       r = 1'b1;
        1:       begin r = tog; tog = ~tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      tx_ready = r;
      // start noise while busy must be ignored
      start = 1'($urandom_range(0, 1));
      dest  = 4'($urandom);
      len   = 4'($urandom);
      if (r) begin
        checks++;
        if (tx_tag !== exp_tag[0] || tx_data !== exp_data[0]) begin
          errors++;
          $display("FAIL beat%0d: tag=%0b data=%0d, required tag=%0b data=%0d",
                   beats, tx_tag, tx_data, exp_tag[0], exp_data[0]);
        end
        $display("beat%0d: tag=%0b data=%0d", beats, tx_tag, tx_data);
        if (exp_tag[0] == 2'b10) model_seq = model_seq + 9'd1;
        void'(exp_tag.pop_front());
        void'(exp_data.pop_front());
        beats++;
      end
      stall = ~r; ptag = tx_tag; pdata = tx_data;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 200) begin
      checks++; errors++;
      $display("FAIL timeout: frame dest=%0d len=%0d not finished after %0d cycles", d, l, cyc);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0 || tx_tag !== 2'b00 || seq !== model_seq) begin
      errors++;
      $display("FAIL frame_end: done=%0b busy=%0b valid=%0b tag=%0b seq=%0d, required 1/0/0/00/%0d",
               done, busy, tx_valid, tx_tag, seq, model_seq);
    end
    $display("frame dest=%0d len=%0d mode=%0d: %0d beats, seq=%0d", d, l, mode, beats, seq);
  endtask

  task automatic test_basic_frame();
    send_frame(4'hA, 4'd3, 0);
    checks++;
    if (seq !== 9'd3) begin errors++; $display("FAIL basic_seq: got %0d required 3", seq); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %0b required 0", done); end
  endtask

  task automatic test_backpressure();
    send_frame(4'hA, 4'd3, 1);
  endtask

  task automatic test_len_zero();
    send_frame(4'h5, 4'd0, 0);
  endtask

  task automatic test_inhibit();
    inhibit = 1'b1; start = 1'b1; dest = 4'($urandom); len = 4'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL inhibit: busy=%0b valid=%0b, required 0/0", busy, tx_valid);
      end
    end
    start = 1'b0; inhibit = 1'b0;
    $display("inhibit: busy=%0b valid=%0b", busy, tx_valid);
  endtask

  task automatic test_seq_wrap();
    while (model_seq <= 9'd495) send_frame(4'($urandom), 4'd15, 2);
    send_frame(4'($urandom), 4'(9'd510 - model_seq), 2);
    checks++;
    if (seq !== 9'd510) begin errors++; $display("FAIL preload: seq=%0d required 510", seq); end
    send_frame(4'h3, 4'd3, 0);
    checks++;
    if (seq !== 9'd1) begin errors++; $display("FAIL wrap: seq=%0d required 1", seq); end
  endtask

  task automatic test_back_to_back();
    // consecutive calls start the next frame in the done cycle
    for (int i = 0; i < 4; i++) send_frame(4'($urandom), 4'($urandom_range(0, 6)), 2);
  endtask

  task automatic test_reset_mid_frame();
    send_start:
    begin
      start = 1'b1; dest = 4'h9; len = 4'd3; tx_ready = 1'b1;
      @(negedge clk); start = 1'b0;          // ADDR visible, transfers
      @(negedge clk);                        // DATA 0 visible, transfers
      @(negedge clk);                        // DATA 1 visible
      checks++;
      if (tx_tag !== 2'b10 || tx_data !== model_seq + 9'd1) begin
        errors++;
        $display("FAIL pre_rst: tag=%0b data=%0d, required 10/%0d", tx_tag, tx_data, model_seq + 9'd1);
      end
      tx_ready = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_seq = '0;
      checks++;
      if ({tx_valid, busy, done, tx_tag, tx_data, seq} !== 15'd0) begin
        errors++;
        $display("FAIL mid_rst: valid=%0b busy=%0b done=%0b tag=%0b data=%0d seq=%0d, required all 0",
                 tx_valid, busy, done, tx_tag, tx_data, seq);
      end
      tx_ready = 1'b1;
      repeat (2) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
          errors++;
          $display("FAIL post_rst: done=%0b busy=%0b valid=%0b, required 0/0/0", done, busy, tx_valid);
        end
      end
      $display("reset mid frame: seq=%0d busy=%0b", seq, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_len_zero();
    test_inhibit();
    test_seq_wrap();
    test_back_to_back();
    test_reset_mid_frame();
    send_frame(4'hC, 4'd2, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
